uart_rx_fifo: RTL

Parametrised UART receiver with a first-word-fall-through receive FIFO. It replaces the fixed 8N1 receive path of the loopback block. It adds configurable data width and stop-bit count, optional parity, framing/parity/overrun error reporting, and ready/valid buffered output. It sits between the board RX pin and the core's input-consuming logic.

---
 rtl/uart_rx_fifo.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with configurable data width, stop-bit count and
// optional parity, feeding a first-word-fall-through FIFO with a ready/valid
// output. Framing, parity and overrun errors are reported on dedicated outputs.
// Optional feature macro: UART_RX_PARITY_EN (one parity bit follows the data).
module uart_rx_fifo #(
  parameter int unsigned CLK_PER_HALF_BIT = 85,
  parameter int unsigned DATA_BITS        = 8,
  parameter int unsigned STOP_BITS        = 1,
  parameter int unsigned PARITY_ODD       = 0,
  parameter int unsigned FIFO_DEPTH       = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          rxd,
  output logic [DATA_BITS-1:0]          rdata,
  output logic                          rvalid,
  input  logic                          rready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  input  logic                          overrun_clr
);

  localparam int unsigned CNT_W  = $clog2(2 * CLK_PER_HALF_BIT);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_FW = PTR_W + 1;

  // Elaboration-time parameter legality
  if (CLK_PER_HALF_BIT < 4) begin : g_bad_cph
    $error("CLK_PER_HALF_BIT must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
    $error("STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD > 1) begin : g_bad_par
    $error("PARITY_ODD must be 0 or 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  typedef enum logic [2:0] {
    S_BREAK,
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic                 rxd_m;
  logic                 rxd_s;

  state_t               state;
  state_t               state_n;
  logic [CNT_W-1:0]     baud_cnt;
  logic [CNT_W-1:0]     baud_cnt_n;
  logic [BIT_W-1:0]     bit_cnt;
  logic [BIT_W-1:0]     bit_cnt_n;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_n;
  logic                 half_tick_c;
  logic                 full_tick_c;
  logic                 push_c;
  logic                 frame_err_c;
  logic                 parity_err_c;
`ifdef UART_RX_PARITY_EN
  logic                 par_acc;
  logic                 par_acc_n;
`endif

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     wr_ptr_n;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     rd_ptr_n;
  logic [CNT_FW-1:0]    count_n;
  logic [DATA_BITS-1:0] rdata_n;
  logic                 pop_c;
  logic                 push_ok_c;
  logic                 drop_c;
  logic                 overrun_n;

  // Two-flop synchronizer; idle-high reset value avoids a false start edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  assign half_tick_c = (baud_cnt == CNT_W'(CLK_PER_HALF_BIT - 1));
  assign full_tick_c = (baud_cnt == CNT_W'(2 * CLK_PER_HALF_BIT - 1));

  // Receiver state and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_BREAK;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_acc    <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_cnt_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      frame_err  <= frame_err_c;
      parity_err <= parity_err_c;
`ifdef UART_RX_PARITY_EN
      par_acc    <= par_acc_n;
`endif
    end
  end

  // Next-state logic: every sample restarts the baud counter, so each sample
  // lands exactly one bit period after the previous one
  always_comb begin
    state_n      = state;
    baud_cnt_n   = baud_cnt + CNT_W'(1);
    bit_cnt_n    = bit_cnt;
    shreg_n      = shreg;
    push_c       = 1'b0;
    frame_err_c  = 1'b0;
    parity_err_c = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_acc_n    = par_acc;
`endif
    case (state)
      S_BREAK: begin
        baud_cnt_n = '0;
        if (rxd_s) state_n = S_IDLE;
      end
      S_IDLE: begin
        // IDLE is only entered with the line high, so a low level is the start edge
        baud_cnt_n = '0;
        if (!rxd_s) state_n = S_START;
      end
      S_START: begin
        if (half_tick_c) begin
          baud_cnt_n = '0;
          bit_cnt_n  = '0;
`ifdef UART_RX_PARITY_EN
          par_acc_n  = 1'b0;
`endif
          state_n    = rxd_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (full_tick_c) begin
          baud_cnt_n = '0;
          shreg_n    = {rxd_s, shreg[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
          par_acc_n  = par_acc ^ rxd_s;
`endif
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            bit_cnt_n = '0;
`ifdef UART_RX_PARITY_EN
            state_n   = S_PARITY;
`else
            state_n   = S_STOP;
`endif
          end else begin
            bit_cnt_n = bit_cnt + BIT_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (full_tick_c) begin
          baud_cnt_n = '0;
          par_acc_n  = par_acc ^ rxd_s;
          state_n    = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (full_tick_c) begin
          baud_cnt_n = '0;
          if (!rxd_s) begin
            frame_err_c = 1'b1;
            state_n     = S_BREAK;
          end else if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            // Return to IDLE mid stop bit so a back-to-back start edge is caught
            state_n = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_acc != 1'(PARITY_ODD)) parity_err_c = 1'b1;
            else                           push_c       = 1'b1;
`else
            push_c  = 1'b1;
`endif
          end else begin
            bit_cnt_n = bit_cnt + BIT_W'(1);
          end
        end
      end
      default: begin
        state_n    = S_BREAK;
        baud_cnt_n = '0;
      end
    endcase
  end

  // FIFO control: a push into a full FIFO survives only if a pop frees a slot
  // in the same cycle; rdata is the registered next head word
  always_comb begin
    pop_c     = rready && (fifo_count != '0);
    push_ok_c = push_c && ((fifo_count != CNT_FW'(FIFO_DEPTH)) || pop_c);
    drop_c    = push_c && !push_ok_c;
    wr_ptr_n  = push_ok_c ? wr_ptr + PTR_W'(1) : wr_ptr;
    rd_ptr_n  = pop_c ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_n   = fifo_count;
    if (push_ok_c && !pop_c) begin
      count_n = fifo_count + CNT_FW'(1);
    end else if (!push_ok_c && pop_c) begin
      count_n = fifo_count - CNT_FW'(1);
    end
    if (push_ok_c && (wr_ptr == rd_ptr_n)) begin
      rdata_n = shreg;
    end else begin
      rdata_n = mem[rd_ptr_n];
    end
    if (drop_c) begin
      overrun_n = 1'b1;
    end else if (overrun_clr) begin
      overrun_n = 1'b0;
    end else begin
      overrun_n = overrun;
    end
  end

  // FIFO pointers, occupancy and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rvalid     <= 1'b0;
      rdata      <= '0;
      overrun    <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      fifo_count <= count_n;
      rvalid     <= (count_n != '0);
      overrun    <= overrun_n;
      if (count_n != '0) rdata <= rdata_n;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= shreg;
  end

endmodule
